time_counter: RTL
=================

# time_counter

Timekeeping core of the digital clock. Consumes the divided 1 Hz square wave from the clock-divider stage and keeps hours, minutes and seconds in packed BCD for the display stage. Also provides a synchronous time-set (load) path with legality checking, a pause control, and single-cycle second-advance and day-wrap pulses.

## Interface
Parameters:
- none; reset time and wrap limits are fixed (see Operation)

Ports:
- clk  in  1  system clock; the same clock that drives the divider
- rst_n  in  1  asynchronous, active-low reset
- sec_clk  in  1  divider output square wave, synchronous to clk; each rising edge is one second
- hold  in  1  level; while 1, second edges are discarded
- load  in  1  single-cycle pulse; requests loading of set_hh/set_mm/set_ss/set_pm
- set_hh  in  8  BCD hours to load
- set_mm  in  8  BCD minutes to load
- set_ss  in  8  BCD seconds to load
- set_pm  in  1  PM flag to load; ignored unless TIME_12H_EN is defined
- hh  out  8  BCD hours
- mm  out  8  BCD minutes
- ss  out  8  BCD seconds
- pm  out  1  PM indicator; constant 0 unless TIME_12H_EN is defined
- sec_tick  out  1  one-cycle pulse each time the time advances by one second
- day_wrap  out  1  one-cycle pulse on the advance to midnight
- load_err  out  1  one-cycle pulse when a load is rejected

## Operation
- Edge detect: register sec_q holds sec_clk from the previous cycle. A second edge is detected when sec_clk=1 and sec_q=0.
- Reset values:
  - sec_q=1, so sec_clk held high at reset release produces no spurious edge.
  - hh/mm/ss = 00:00:00 in 24 h mode; 12:00:00 with pm=0 in 12 h mode.
  - sec_tick, day_wrap and load_err are 0.
- Priority each cycle: load > hold > second edge.
- Second advance:
  - ss increments; at 59, ss→00 and mm increments.
  - At mm 59, mm→00 and hh increments.
  - BCD rule: low digit 9→0 with carry into the high digit.
- 24 h wrap: 23:59:59 → 00:00:00, with day_wrap pulsing.
- Load:
  - When all fields are legal, outputs take the set values and sec_tick is not asserted.
  - When any field is illegal, the time is unchanged and load_err pulses.
  - Illegal fields:
    - any nibble > 9;
    - ss or mm > 0x59;
    - hh > 0x23 in 24 h mode;
    - hh = 0x00 or hh > 0x12 in 12 h mode.
- Load coinciding with a second edge: the load is applied and the edge is dropped. An edge is never deferred.
- hold=1: edges are dropped, not accumulated, and sec_tick stays 0. Load is still accepted.
- Reset asserted mid-operation: all state returns immediately to its reset value. No edge or pending load survives.

## Timing
- Edge sampled at clock edge k: hh/mm/ss show the new value after edge k, and sec_tick/day_wrap are high for the cycle following edge k.
- Load sampled at edge k: the new time, or load_err, is visible after edge k. Latency is 1 cycle.
- At most one advance per sec_clk period. sec_clk must stay high for ≥1 clk and low for ≥1 clk.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- TIME_12H_EN defined (12 h mode):
  - hours run 12, 01 … 11, 12.
  - 11:59:59 AM → 12:00:00 PM sets pm=1.
  - 11:59:59 PM → 12:00:00 AM clears pm and pulses day_wrap.
  - 12:59:59 → 01:00:00 leaves pm unchanged.
  - Load also captures set_pm.
- TIME_12H_EN undefined (24 h mode): hours run 00–23, pm is tied to 0, and set_pm is unused.

## Structure
- Shared package clock_pkg:
  - BCD byte typedef;
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HR24_MAX=8'h23, HR12_MAX=8'h12;
  - BCD legality function.
- One sub-module, bcd_mod_counter: two-digit BCD counter with inc, load, load value, max value, and wrap value, plus a carry output. It is instantiated three times (ss, mm, hh). In 12 h mode the hours wrap value is 01.

## Test plan
- Reset, then 60 sec_clk edges → ss counts 00…59, then mm=01, ss=00, with exactly 60 sec_tick pulses.
- Load 23:59:58, then 2 edges → 23:59:59, then 00:00:00 with one day_wrap pulse (24 h build).
- Load set_hh=8'h24, or set_mm=8'h5A → load_err pulses once and the time is unchanged.
- load in the same cycle as a second edge with set 10:20:30 → output is 10:20:30, sec_tick=0, and the next edge gives 10:20:31.
- hold=1 across 3 edges, then release → time frozen, no sec_tick, and the following edge advances by exactly 1 s.
- 12 h build: load 11:59:59 with set_pm=0, then 1 edge → 12:00:00 pm=1. Load 11:59:59 with set_pm=1, then 1 edge → 12:00:00 pm=0 and day_wrap pulses.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types, limits and BCD legality helper for the digital-clock timekeeping core.
package clock_pkg;

    typedef logic [7:0] bcd_t;

    localparam bcd_t SEC_MAX  = 8'h59;
    localparam bcd_t MIN_MAX  = 8'h59;
    localparam bcd_t HR24_MAX = 8'h23;
    localparam bcd_t HR12_MAX = 8'h12;

    // Valid BCD orders the same as binary, so a plain compare against the limit works.
    function automatic logic bcd_legal(input bcd_t v, input bcd_t max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with synchronous load, programmable max/wrap and carry out.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd_t RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] max_val_i,
    input  logic [7:0] wrap_val_i,
    output logic [7:0] val_o,
    output logic       carry_c_o
);

    bcd_t val_q, val_d;

    assign carry_c_o = inc_i && !load_i && (val_q == max_val_i);
    assign val_o     = val_q;

    always_comb begin
        val_d = val_q;
        if (load_i) begin
            val_d = load_val_i;
        end else if (inc_i) begin
            if (val_q == max_val_i) begin
                val_d = wrap_val_i;
            end else if (val_q[3:0] == 4'd9) begin
                val_d = {val_q[7:4] + 4'd1, 4'd0};
            end else begin
                val_d = {val_q[7:4], val_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= RST_VAL;
        end else begin
            val_q <= val_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Timekeeping core: BCD hh:mm:ss advanced by 1 Hz edges, with checked load and hold.
// Define TIME_12H_EN for 12 h mode with PM flag; default build counts 00-23.
module time_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_clk,
    input  logic       hold,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       set_pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_wrap,
    output logic       load_err
);

`ifdef TIME_12H_EN
    localparam bcd_t HR_MAX  = HR12_MAX;
    localparam bcd_t HR_WRAP = 8'h01;
    localparam bcd_t HR_RST  = 8'h12;
`else
    localparam bcd_t HR_MAX  = HR24_MAX;
    localparam bcd_t HR_WRAP = 8'h00;
    localparam bcd_t HR_RST  = 8'h00;
`endif

    logic sec_q, sec_d;
    logic pm_q, pm_d;
    logic tick_q, tick_d;
    logic wrap_q, wrap_d;
    logic err_q, err_d;

    logic edge_c, adv_c, load_ok_c, ld_c, noon_c;
    logic ss_carry_c, mm_carry_c, hh_carry_c;
    logic unused_c;

    assign edge_c = sec_clk & ~sec_q;
    // Load wins over hold, hold wins over the edge; a dropped edge is never replayed.
    assign adv_c  = edge_c & ~hold & ~load;

`ifdef TIME_12H_EN
    assign load_ok_c = bcd_legal(set_ss, SEC_MAX) && bcd_legal(set_mm, MIN_MAX)
                    && bcd_legal(set_hh, HR_MAX) && (set_hh != 8'h00);
`else
    assign load_ok_c = bcd_legal(set_ss, SEC_MAX) && bcd_legal(set_mm, MIN_MAX)
                    && bcd_legal(set_hh, HR_MAX);
`endif
    assign ld_c     = load & load_ok_c;
    assign noon_c   = mm_carry_c && (hh == 8'h11);
    assign unused_c = set_pm ^ hh_carry_c ^ noon_c;

    bcd_mod_counter #(.RST_VAL(8'h00)) u_ss (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (adv_c),
        .load_i     (ld_c),
        .load_val_i (set_ss),
        .max_val_i  (SEC_MAX),
        .wrap_val_i (8'h00),
        .val_o      (ss),
        .carry_c_o  (ss_carry_c)
    );

    bcd_mod_counter #(.RST_VAL(8'h00)) u_mm (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (ss_carry_c),
        .load_i     (ld_c),
        .load_val_i (set_mm),
        .max_val_i  (MIN_MAX),
        .wrap_val_i (8'h00),
        .val_o      (mm),
        .carry_c_o  (mm_carry_c)
    );

    bcd_mod_counter #(.RST_VAL(HR_RST)) u_hh (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (mm_carry_c),
        .load_i     (ld_c),
        .load_val_i (set_hh),
        .max_val_i  (HR_MAX),
        .wrap_val_i (HR_WRAP),
        .val_o      (hh),
        .carry_c_o  (hh_carry_c)
    );

    always_comb begin
        sec_d  = sec_clk;
        pm_d   = pm_q;
        tick_d = adv_c;
        wrap_d = 1'b0;
        err_d  = load & ~load_ok_c;
`ifdef TIME_12H_EN
        // 11 -> 12 flips AM/PM; the PM -> AM flip is midnight.
        if (ld_c) begin
            pm_d = set_pm;
        end else if (noon_c) begin
            pm_d = ~pm_q;
        end
        wrap_d = noon_c & pm_q;
`else
        pm_d   = 1'b0;
        wrap_d = hh_carry_c;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q  <= 1'b1;
            pm_q   <= 1'b0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            pm_q   <= pm_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign pm       = pm_q;
    assign sec_tick = tick_q;
    assign day_wrap = wrap_q;
    assign load_err = err_q;

endmodule
